// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- direct-mapped, write-back, write-allocate data cache.
//
// Sits between the CPU datapath and a 32-bit-word data memory. Hits complete
// with zero stall. A miss raises BUSYWAIT in the same cycle. It then walks
// IDLE -> [WRITEBACK] -> FETCH -> UPDATE -> IDLE. Once back in IDLE, the held
// CPU request hits and completes.
//
// Optional feature: define DCACHE_STATS_EN to add saturating hit/miss counters.
//
// Ports
//   CLK, RESET                  clock, synchronous active-high reset
//   READ, WRITE                 CPU load/store request (READ wins if both set)
//   ADDRESS[ADDR_W-1:0]         byte address {tag, index, offset[1:0]}
//   WRITEDATA[7:0]              store byte
//   READDATA[7:0]               load byte (combinational on a read hit)
//   BUSYWAIT                    CPU stall
//   mem_read, mem_write         memory block request (registered)
//   mem_address[ADDR_W-3:0]     block address {tag, index}
//   mem_writedata[31:0]         evicted block, byte0 in [7:0]
//   mem_readdata[31:0]          fetched block, byte0 in [7:0]
//   mem_busywait                memory busy
//   hit_count, miss_count       (DCACHE_STATS_EN only) request counters
module dcache_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                READ,
  input  logic                WRITE,
  input  logic [ADDR_W-1:0]   ADDRESS,
  input  logic [7:0]          WRITEDATA,
  output logic [7:0]          READDATA,
  output logic                BUSYWAIT,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-3:0]   mem_address,
  output logic [31:0]         mem_writedata,
  input  logic [31:0]         mem_readdata,
  input  logic                mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int NBLK  = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t             state;
  logic [NBLK-1:0]    valid, dirty;
  logic [TAG_W-1:0]   tags [NBLK];
  logic [31:0]        data [NBLK];
  logic [31:0]        fill;
  logic [7:0]         rd_hold;
  logic [7:0]         sel_byte;

  logic [TAG_W-1:0]   atag;
  logic [INDEX_W-1:0] idx;
  logic [1:0]         off;
  logic               req, hit, idle, rd_hit, wr_hit, miss;

  assign atag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign idx  = ADDRESS[2 +: INDEX_W];
  assign off  = ADDRESS[1:0];

  assign req    = READ | WRITE;
  assign idle   = (state == IDLE);
  assign hit    = valid[idx] && (tags[idx] == atag);
  assign rd_hit = idle && READ && hit;
  // A simultaneous READ and WRITE is serviced as a read; the store is dropped.
  assign wr_hit = idle && WRITE && !READ && hit;
  assign miss   = idle && req && !hit;

  always_comb begin
    sel_byte = 8'h00;
    case (off)
      2'd0: sel_byte = data[idx][7:0];
      2'd1: sel_byte = data[idx][15:8];
      2'd2: sel_byte = data[idx][23:16];
      2'd3: sel_byte = data[idx][31:24];
      default: sel_byte = 8'h00;
    endcase
  end

  // The stall covers the IDLE miss cycle combinationally, and every non-IDLE state.
  assign BUSYWAIT = !idle || (req && !hit);
  // Outside a read hit, the last delivered byte is held.
  assign READDATA = rd_hit ? sel_byte : rd_hold;

  // Controller state, memory handshake and block status bits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      valid         <= '0;
      dirty         <= '0;
      rd_hold       <= 8'h00;
`ifdef DCACHE_STATS_EN
      hit_count     <= 16'h0000;
      miss_count    <= 16'h0000;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rd_hit) rd_hold <= sel_byte;
          if (wr_hit) dirty[idx] <= 1'b1;
`ifdef DCACHE_STATS_EN
          if ((rd_hit || wr_hit) && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
          if (miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
`endif
          if (miss) begin
            if (dirty[idx]) begin
              mem_write     <= 1'b1;
              mem_address   <= {tags[idx], idx};
              mem_writedata <= data[idx];
              state         <= WRITEBACK;
            end else begin
              mem_read    <= 1'b1;
              mem_address <= {atag, idx};
              state       <= FETCH;
            end
          end
        end
        WRITEBACK: if (!mem_busywait) begin
          // Hand straight over to the fetch; read and write never overlap.
          mem_write   <= 1'b0;
          mem_read    <= 1'b1;
          mem_address <= {atag, idx};
          state       <= FETCH;
        end
        FETCH: if (!mem_busywait) begin
          mem_read <= 1'b0;
          state    <= UPDATE;
        end
        UPDATE: begin
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data, tag and fill storage. These need no reset: valid gates all use.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state == FETCH && !mem_busywait) fill <= mem_readdata;
      if (state == UPDATE) begin
        data[idx] <= fill;
        tags[idx] <= atag;
      end else if (wr_hit) begin
        data[idx][{off, 3'b000} +: 8] <= WRITEDATA;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl -- directed scoreboard bench for dcache_ctrl.
// The memory model is busy for 5 cycles per request, then ready for 1 cycle.
// It returns {a+3,a+2,a+1,a}, where a = {mem_address,2'b00}.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
  logic [15:0] hc0, mc0;
`endif

  dcache_ctrl dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory model
  localparam int MEM_BUSY = 5;
  int         mcnt = 0;
  logic [7:0] ma;
  always @(posedge CLK) begin
    if (!(mem_read === 1'b1 || mem_write === 1'b1) || mcnt == MEM_BUSY) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end
  assign mem_busywait = (mem_read === 1'b1 || mem_write === 1'b1) && (mcnt != MEM_BUSY);
  assign ma           = {mem_address, 2'b00};
  assign mem_readdata = {ma + 8'd3, ma + 8'd2, ma + 8'd1, ma};

  // Scoreboards
  typedef struct { string tag; logic [7:0] rdata; int stalls; bit chk_rd; } cpu_exp_t;
  typedef struct { string tag; bit wr; logic [5:0] addr; logic [31:0] wdata; } mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  mem_exp_t me;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Memory-side monitor: compare each new memory request against the next expectation.
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  always @(negedge CLK) begin
    if ((mem_read === 1'b1 && !prev_rd) || (mem_write === 1'b1 && !prev_wr)) begin
      if (mem_q.size() == 0) begin
        chk("mem_unexpected_req", {mem_read, mem_write}, 32'd0);
      end else begin
        me = mem_q.pop_front();
        chk({me.tag, "_kind"}, mem_write, me.wr);
        chk({me.tag, "_addr"}, mem_address, me.addr);
        if (me.wr) chk({me.tag, "_wdata"}, mem_writedata, me.wdata);
      end
      chk("mem_exclusive", mem_read & mem_write, 32'd0);
    end
    prev_rd <= (mem_read === 1'b1);
    prev_wr <= (mem_write === 1'b1);
  end

  // Present one CPU request, hold it until BUSYWAIT drops, check completion.
  task automatic do_req(input string tag, input bit rd, input bit wr,
                        input logic [7:0] addr, input logic [7:0] wd,
                        input bit exp_miss, input int exp_stalls,
                        input logic [7:0] exp_rd);
    cpu_exp_t e;
    int stalls = 0;
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    cpu_q.push_back('{tag, exp_rd, exp_stalls, rd});
    @(negedge CLK);
    chk({tag, "_busy0"}, BUSYWAIT, exp_miss);
    if (!exp_miss) chk({tag, "_memrd0"}, mem_read, 1'b0);
    for (int i = 0; i < 100 && BUSYWAIT !== 1'b0; i++) begin
      @(negedge CLK);
      if (BUSYWAIT !== 1'b0) stalls++;
    end
    chk({tag, "_done"}, BUSYWAIT, 1'b0);
    e = cpu_q.pop_front();
    chk({e.tag, "_stalls"}, stalls, e.stalls);
    if (e.chk_rd) chk({e.tag, "_rdata"}, READDATA, e.rdata);
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_busy",   BUSYWAIT, 1'b0);
    chk("rst_mrd",    mem_read, 1'b0);
    chk("rst_mwr",    mem_write, 1'b0);
    chk("rst_maddr",  mem_address, 6'h00);
    chk("rst_mwdata", mem_writedata, 32'h0);
    chk("rst_rdata",  READDATA, 8'h00);
`ifdef DCACHE_STATS_EN
    chk("rst_hits",   hit_count, 16'h0);
    chk("rst_misses", miss_count, 16'h0);
`endif

    // 1: cold read, clean miss
    mem_q.push_back('{"t1_fetch", 1'b0, 6'h05, 32'h0});
    do_req("t1", 1, 0, 8'h14, 8'h00, 1, 7, 8'h14);
    // 2: neighbouring byte hits
    do_req("t2", 1, 0, 8'h15, 8'h00, 0, 0, 8'h15);
    // 3: write hit, then read back
    do_req("t3w", 0, 1, 8'h14, 8'hAB, 0, 0, 8'h00);
    do_req("t3r", 1, 0, 8'h14, 8'h00, 0, 0, 8'hAB);
    // 4: conflicting store on dirty index 5: writeback, then fetch, then allocate
    mem_q.push_back('{"t4_wb",    1'b1, 6'h05, 32'h171615AB});
    mem_q.push_back('{"t4_fetch", 1'b0, 6'h0D, 32'h0});
    do_req("t4w",  0, 1, 8'h34, 8'h5A, 1, 13, 8'h00);
    do_req("t4r0", 1, 0, 8'h34, 8'h00, 0, 0, 8'h5A);
    do_req("t4r1", 1, 0, 8'h35, 8'h00, 0, 0, 8'h35);

    // 5: reset while FETCH is outstanding
    mem_q.push_back('{"t5_fetch", 1'b0, 6'h02, 32'h0});
    @(posedge CLK); #1;
    READ = 1'b1; ADDRESS = 8'h08;
    for (int i = 0; i < 20 && mem_read !== 1'b1; i++) @(negedge CLK);
    chk("t5_inflight", mem_read, 1'b1);
    @(posedge CLK); #1;
    RESET = 1'b1; READ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("t5_mrd",   mem_read, 1'b0);
    chk("t5_mwr",   mem_write, 1'b0);
    chk("t5_busy",  BUSYWAIT, 1'b0);
    chk("t5_rdata", READDATA, 8'h00);
    mem_q.push_back('{"t5_refetch", 1'b0, 6'h05, 32'h0});
    do_req("t5r", 1, 0, 8'h14, 8'h00, 1, 7, 8'h14);

    // 6: READ and WRITE together are serviced as a read only
`ifdef DCACHE_STATS_EN
    @(negedge CLK);
    hc0 = hit_count; mc0 = miss_count;
`endif
    do_req("t6rw", 1, 1, 8'h15, 8'hFF, 0, 0, 8'h15);
`ifdef DCACHE_STATS_EN
    @(negedge CLK);
    chk("t6_hits",   hit_count, hc0 + 16'd1);
    chk("t6_misses", miss_count, mc0);
`endif
    do_req("t6r", 1, 0, 8'h15, 8'h00, 0, 0, 8'h15);

    // 7: clean write miss allocates the block and merges the store
    mem_q.push_back('{"t7_fetch", 1'b0, 6'h02, 32'h0});
    do_req("t7w",  0, 1, 8'h0B, 8'h77, 1, 7, 8'h00);
    do_req("t7r3", 1, 0, 8'h0B, 8'h00, 0, 0, 8'h77);
    do_req("t7r2", 1, 0, 8'h0A, 8'h00, 0, 0, 8'h0A);

    repeat (3) @(negedge CLK);
    chk("cpu_q_empty", cpu_q.size(), 32'd0);
    chk("mem_q_empty", mem_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
